// File: rtl/seq_alu.sv
// Handshaked multi-cycle unsigned ALU: add/sub complete in one cycle, while mul (shift-add)
// and div (restoring) iterate one bit per cycle. The result is held in DONE until it is taken.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op_code,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero,
  output logic                 busy
);

  localparam int unsigned RW   = 2 * WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic              is_div_q, is_div_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // acc: running product (mul) or partial remainder in the low half (div)
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     mcand_q, mcand_d;
  // opb: remaining multiplier bits (mul) or divisor (div)
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [RW-1:0]     result_q, result_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    diff;
  logic [WIDTH-1:0]  rem_nx;
  logic              qbit;
  logic              last_iter;

  assign last_iter = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    quo_d    = quo_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    shifted  = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, opb_q};
    qbit     = ~diff[WIDTH];
    rem_nx   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          unique case (op_code)
            OpAdd: begin
              result_d = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
              dbz_d    = 1'b0;
              state_d  = StDone;
            end
            OpSub: begin
              result_d = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
              dbz_d    = 1'b0;
              state_d  = StDone;
            end
            OpMul: begin
              acc_d    = '0;
              mcand_d  = {{WIDTH{1'b0}}, a};
              opb_d    = b;
              cnt_d    = '0;
              is_div_d = 1'b0;
              state_d  = StCalc;
            end
            OpDiv: begin
              if (b == '0) begin
                result_d = '1;
                dbz_d    = 1'b1;
                state_d  = StDone;
              end else begin
                acc_d    = '0;
                quo_d    = a;
                opb_d    = b;
                cnt_d    = '0;
                is_div_d = 1'b1;
                state_d  = StCalc;
              end
            end
            default: ;
          endcase
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        if (!is_div_q) begin
          if (opb_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          opb_d   = opb_q >> 1;
          if (last_iter) begin
            result_d = acc_d;
            dbz_d    = 1'b0;
            state_d  = StDone;
          end
        end else begin
          acc_d = {{WIDTH{1'b0}}, rem_nx};
          quo_d = {quo_q[WIDTH-2:0], qbit};
          if (last_iter) begin
            result_d = {rem_nx, quo_d};
            dbz_d    = 1'b0;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  // Status outputs decode straight from the state register only.
  assign in_ready    = (state_q == StIdle);
  assign busy        = (state_q == StCalc);
  assign out_valid   = (state_q == StDone);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule
